// File: rtl/audio_pacer_pkg.sv
// Shared types and constants for the audio FIFO pacer.
package audio_pacer_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DIV_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } pacer_state_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/audio_fifo_pacer_if.sv
// Bridge/codec-side signal bundle for audio_fifo_pacer.
// master = bridge side (drives writes and playback control), slave = pacer.
interface audio_fifo_pacer_if #(
  parameter int unsigned DATA_W = audio_pacer_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = audio_pacer_pkg::DEF_ADDR_W,
  parameter int unsigned DIV_W  = audio_pacer_pkg::DEF_DIV_W
) ();

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic [DIV_W-1:0]  div_freq;
  logic              pause;
  logic              stop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_used;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              underflow;
  logic              overflow;

  modport master (
    output wr_req, wr_data, div_freq, pause, stop,
    input  fifo_full, fifo_empty, fifo_used, sample_out, sample_valid,
           underflow, overflow
  );

  modport slave (
    input  wr_req, wr_data, div_freq, pause, stop,
    output fifo_full, fifo_empty, fifo_used, sample_out, sample_valid,
           underflow, overflow
  );

endinterface

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO: dual-port RAM, wrapping pointers, occupancy count,
// registered full/empty and registered read data. clr flushes synchronously.
module audio_sync_fifo #(
  parameter int unsigned DATA_W = audio_pacer_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = audio_pacer_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   used,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ok
);
  import audio_pacer_pkg::*;

  localparam int unsigned     DEPTH     = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   used_next;
  logic              wr_ok;

  // Accept/pop decisions; a pop frees the slot a same-cycle write needs when full
  always_comb begin
    rd_ok     = rd_en && !empty && !clr;
    wr_ok     = wr_en && (!full || rd_ok) && !clr;
    used_next = used + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and flags, all kept in step with used_next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      used  <= used_next;
      full  <= (used_next == DEPTH_CNT);
      empty <= (used_next == '0);
    end
  end

  // Registered read data; rd_zero loads a silent word instead of popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data <= '0;
    else if (clr)     rd_data <= '0;
    else if (rd_ok)   rd_data <= mem[rd_ptr];
    else if (rd_zero) rd_data <= '0;
  end

endmodule

// File: rtl/audio_fifo_pacer.sv
// audio_fifo_pacer: buffers audio words from the audio2fifo bridge and
// releases one word every div_freq clocks toward the codec, under pause/stop.
// Optional build macro AUDIO_PACER_MUTE_ON_UNDERFLOW_EN: a tick with the FIFO
// empty emits a zero sample (with sample_valid) instead of holding the last.
module audio_fifo_pacer #(
  parameter int unsigned DATA_W = audio_pacer_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = audio_pacer_pkg::DEF_ADDR_W,
  parameter int unsigned DIV_W  = audio_pacer_pkg::DEF_DIV_W
) (
  input  logic              clk,
  input  logic              reset_n,
  audio_fifo_pacer_if.slave bus
);
  import audio_pacer_pkg::*;

  logic              rst_meta;
  logic              rst_sync_n;
  pacer_state_e      state_q;
  pacer_state_e      state_d;
  logic              run_en;
  logic              tick;
  logic              zero_tick;
  logic              wr_en;
  logic [DIV_W-1:0]  div_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_ok;
  logic [ADDR_W:0]   fifo_used;
  logic [DATA_W-1:0] rd_data;
  logic              sample_valid;
  logic              underflow;
  logic              overflow;

  // Reset asserts at once and releases two clocks after reset_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Playback state register
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; stop overrides everything, including pause
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!bus.pause && (bus.div_freq != '0)) state_d = RUN;
        RUN:     if (bus.pause) state_d = PAUSED;
        PAUSED:  if (!bus.pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pacer outputs; pause gates the divider in the same cycle it rises, and a
  // >= compare lets a shrunken div_freq tick and wrap straight away
  always_comb begin
    run_en    = (state_q == RUN) && !bus.pause && !bus.stop;
    tick      = run_en && (bus.div_freq != '0) &&
                (div_cnt >= bus.div_freq - DIV_W'(1));
    zero_tick = 1'b0;
`ifdef AUDIO_PACER_MUTE_ON_UNDERFLOW_EN
    zero_tick = tick && fifo_empty;
`endif
    wr_en     = bus.wr_req && !bus.stop;
  end

  // Sample-period divider; held while paused or halted (div_freq = 0)
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)                          div_cnt <= '0;
    else if (bus.stop || tick)                div_cnt <= '0;
    else if (run_en && (bus.div_freq != '0)) div_cnt <= div_cnt + DIV_W'(1);
  end

  // Output strobe and sticky error flags
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
      overflow     <= 1'b0;
    end else if (bus.stop) begin
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sample_valid <= rd_ok || zero_tick;
      if (tick && fifo_empty)                  underflow <= 1'b1;
      if (bus.wr_req && fifo_full && !rd_ok)   overflow  <= 1'b1;
    end
  end

  audio_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_sync_n),
    .clr     (bus.stop),
    .wr_en   (wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (tick),
    .rd_zero (zero_tick),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .used    (fifo_used),
    .rd_data (rd_data),
    .rd_ok   (rd_ok)
  );

  assign bus.fifo_full    = fifo_full;
  assign bus.fifo_empty   = fifo_empty;
  assign bus.fifo_used    = fifo_used;
  assign bus.sample_out   = rd_data;
  assign bus.sample_valid = sample_valid;
  assign bus.underflow    = underflow;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_audio_fifo_pacer.sv
// Directed self-checking bench for audio_fifo_pacer (default 32/11/32 build).
// Expectations depend on AUDIO_PACER_MUTE_ON_UNDERFLOW_EN where underflow ticks occur.
module tb_audio_fifo_pacer;
  import audio_pacer_pkg::*;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  audio_fifo_pacer_if #(.DATA_W(32), .ADDR_W(11), .DIV_W(32)) bus ();

  audio_fifo_pacer #(.DATA_W(32), .ADDR_W(11), .DIV_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic        exp_v;
    logic        saw_v;
    int          npop;
    logic [31:0] first_s;
    logic [31:0] last_s;
    logic        mute;

    n_pass  = 0;
    n_total = 0;
    first_s = '0;
    last_s  = '0;
`ifdef AUDIO_PACER_MUTE_ON_UNDERFLOW_EN
    mute = 1'b1;
`else
    mute = 1'b0;
`endif

    reset_n      = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_data  = '0;
    bus.div_freq = '0;
    bus.pause    = 1'b0;
    bus.stop     = 1'b0;

    // ---- reset values ----
    repeat (3) step();
    chk("rst_empty", 64'(bus.fifo_empty), 64'(1));
    chk("rst_full", 64'(bus.fifo_full), 64'(0));
    chk("rst_used", 64'(bus.fifo_used), 64'(0));
    chk("rst_sample", 64'(bus.sample_out), 64'(0));
    chk("rst_valid", 64'(bus.sample_valid), 64'(0));
    chk("rst_underflow", 64'(bus.underflow), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    reset_n = 1'b1;
    repeat (3) step();

    // ---- T1: four words at div_freq=4 ----
    for (int i = 1; i <= 4; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'(i);
      step();
    end
    bus.wr_req = 1'b0;
    chk("t1_used4", 64'(bus.fifo_used), 64'(4));
    chk("t1_not_empty", 64'(bus.fifo_empty), 64'(0));
    bus.div_freq = 32'd4;
    for (int k = 1; k <= 21; k++) begin
      step();
      exp_v = (k == 5) || (k == 9) || (k == 13) || (k == 17) || (mute && (k == 21));
      chk("t1_valid", 64'(bus.sample_valid), 64'(exp_v));
      if (exp_v && (k < 21)) chk("t1_sample", 64'(bus.sample_out), 64'((k - 1) / 4));
      if (k == 20) chk("t1_no_underflow_yet", 64'(bus.underflow), 64'(0));
    end
    chk("t1_underflow", 64'(bus.underflow), 64'(1));
    chk("t1_empty", 64'(bus.fifo_empty), 64'(1));
    chk("t1_sample_after_underflow", 64'(bus.sample_out), mute ? 64'(0) : 64'(4));

    bus.stop     = 1'b1;
    bus.div_freq = '0;
    step();
    bus.stop = 1'b0;
    chk("t1_stop_underflow_clr", 64'(bus.underflow), 64'(0));
    chk("t1_stop_sample_clr", 64'(bus.sample_out), 64'(0));

    // ---- T2a: fill to exactly 2048 with the pacer halted ----
    for (int i = 0; i < 2048; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h1000_0000 + 32'(i);
      step();
      if (i == 2046) begin
        chk("t2_used_2047", 64'(bus.fifo_used), 64'(2047));
        chk("t2_not_full_2047", 64'(bus.fifo_full), 64'(0));
      end
    end
    bus.wr_req = 1'b0;
    chk("t2_used_2048", 64'(bus.fifo_used), 64'(2048));
    chk("t2_full", 64'(bus.fifo_full), 64'(1));
    chk("t2_not_empty", 64'(bus.fifo_empty), 64'(0));
    chk("t2_no_overflow", 64'(bus.overflow), 64'(0));

    // ---- T3: full FIFO, div_freq=1, write every cycle ----
    bus.div_freq = 32'd1;
    step();
    for (int j = 0; j < 100; j++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h2000_0000 + 32'(j);
      step();
      chk("t3_valid", 64'(bus.sample_valid), 64'(1));
      chk("t3_sample", 64'(bus.sample_out), 64'(32'h1000_0000 + 32'(j)));
      chk("t3_used", 64'(bus.fifo_used), 64'(2048));
      chk("t3_no_overflow", 64'(bus.overflow), 64'(0));
    end
    bus.wr_req   = 1'b0;
    bus.div_freq = '0;
    step();
    chk("t3_halt_valid", 64'(bus.sample_valid), 64'(0));
    chk("t3_halt_used", 64'(bus.fifo_used), 64'(2048));

    // ---- T2b: one more write while full is dropped ----
    bus.wr_req  = 1'b1;
    bus.wr_data = 32'h3000_0000;
    step();
    bus.wr_req = 1'b0;
    chk("t2b_overflow", 64'(bus.overflow), 64'(1));
    chk("t2b_used", 64'(bus.fifo_used), 64'(2048));
    chk("t2b_full", 64'(bus.fifo_full), 64'(1));

    // ---- drain: dropped word must never appear ----
    npop = 0;
    bus.div_freq = 32'd1;
    for (int i = 0; i < 2048; i++) begin
      step();
      if (bus.sample_valid) begin
        npop++;
        if (npop == 1) first_s = bus.sample_out;
        last_s = bus.sample_out;
      end
    end
    chk("drain_count", 64'(npop), 64'(2048));
    chk("drain_first", 64'(first_s), 64'(32'h1000_0064));
    chk("drain_last", 64'(last_s), 64'(32'h2000_0063));
    chk("drain_empty", 64'(bus.fifo_empty), 64'(1));
    chk("drain_used0", 64'(bus.fifo_used), 64'(0));
    chk("drain_no_underflow_yet", 64'(bus.underflow), 64'(0));
    step();
    chk("drain_underflow", 64'(bus.underflow), 64'(1));
    chk("drain_uf_valid", 64'(bus.sample_valid), 64'(mute));
    chk("drain_uf_sample", 64'(bus.sample_out), mute ? 64'(0) : 64'(32'h2000_0063));
    bus.div_freq = '0;

    // ---- T5: stop with 100 words buffered and both flags set ----
    for (int i = 0; i < 100; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h5000_0000 + 32'(i);
      step();
    end
    chk("t5_used100", 64'(bus.fifo_used), 64'(100));
    chk("t5_pre_underflow", 64'(bus.underflow), 64'(1));
    chk("t5_pre_overflow", 64'(bus.overflow), 64'(1));
    bus.stop     = 1'b1;
    bus.wr_req   = 1'b1;
    bus.wr_data  = 32'h5555_5555;
    bus.div_freq = 32'd1;
    step();
    chk("t5_used", 64'(bus.fifo_used), 64'(0));
    chk("t5_empty", 64'(bus.fifo_empty), 64'(1));
    chk("t5_full", 64'(bus.fifo_full), 64'(0));
    chk("t5_sample", 64'(bus.sample_out), 64'(0));
    chk("t5_valid", 64'(bus.sample_valid), 64'(0));
    chk("t5_underflow", 64'(bus.underflow), 64'(0));
    chk("t5_overflow", 64'(bus.overflow), 64'(0));
    chk("t5_state", 64'(dut.state_q), 64'(IDLE));
    bus.stop     = 1'b0;
    bus.wr_req   = 1'b0;
    bus.div_freq = '0;
    step();
    chk("t5_idle_hold", 64'(dut.state_q), 64'(IDLE));
    chk("t5_used_hold", 64'(bus.fifo_used), 64'(0));

    // ---- T4: pause mid-period at div_freq=10 ----
    for (int i = 0; i < 10; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h4000_0000 + 32'(i);
      step();
    end
    bus.wr_req   = 1'b0;
    bus.div_freq = 32'd10;
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_v = (k == 11) || (k == 21);
      chk("t4_valid", 64'(bus.sample_valid), 64'(exp_v));
      if (k == 11) chk("t4_sample0", 64'(bus.sample_out), 64'(32'h4000_0000));
      if (k == 21) chk("t4_sample1", 64'(bus.sample_out), 64'(32'h4000_0001));
    end
    bus.pause = 1'b1;
    saw_v = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.sample_valid) saw_v = 1'b1;
    end
    chk("t4_no_tick_paused", 64'(saw_v), 64'(0));
    chk("t4_state_paused", 64'(dut.state_q), 64'(PAUSED));
    bus.pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t4_resume_valid", 64'(bus.sample_valid), 64'(k == 8));
      if (k == 8) chk("t4_sample2", 64'(bus.sample_out), 64'(32'h4000_0002));
    end

    // ---- empty FIFO at div_freq=3 (mute behaviour when enabled) ----
    bus.stop     = 1'b1;
    bus.div_freq = '0;
    step();
    bus.stop     = 1'b0;
    bus.div_freq = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = mute && ((k == 4) || (k == 7) || (k == 10));
      chk("m_valid", 64'(bus.sample_valid), 64'(exp_v));
      chk("m_sample", 64'(bus.sample_out), 64'(0));
      chk("m_underflow", 64'(bus.underflow), 64'(k >= 4));
    end

    // ---- asynchronous reset mid-operation and synchronised release ----
    bus.div_freq = '0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'h6000_0000 + 32'(i);
      step();
    end
    bus.wr_req = 1'b0;
    chk("ar_used3", 64'(bus.fifo_used), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_used", 64'(bus.fifo_used), 64'(0));
    chk("ar_empty", 64'(bus.fifo_empty), 64'(1));
    chk("ar_underflow", 64'(bus.underflow), 64'(0));
    chk("ar_state", 64'(dut.state_q), 64'(IDLE));
    step();
    reset_n     = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_data = 32'h7000_0000;
    step();
    chk("ar_sync_edge1", 64'(bus.fifo_used), 64'(0));
    step();
    chk("ar_sync_edge2", 64'(bus.fifo_used), 64'(0));
    step();
    chk("ar_first_write", 64'(bus.fifo_used), 64'(1));
    bus.wr_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
